fpnew_rounding_multi: RTL and testbench
=======================================

Name: fpnew_rounding_multi

Overview:
- Multi-lane, pipelined successor to the scalar FP rounding stage. Rounds NumLanes packed absolute values in parallel under one rounding mode.
- Supports RNE/RTZ/RDN/RUP/RMM plus stochastic (RSR) and random (RR) rounding, using a per-lane internal LFSR.
- Sits between the normalisation stage and result packing of the vectorial FMA/cast units.
- Adds a valid/ready pipeline, a flush input, per-lane inexact/carry flags and accumulated sticky status.

Parameters:
- NumLanes, 4, number of independent rounding lanes.
- AbsWidth, 16, width of each lane's absolute value, sign excluded.
- RsrPrecision, 12, number of trailing bits compared in RSR.
- NumPipeRegs, 1, register stages after the rounding logic; 0 means fully combinational.
- LfsrSeed, 32'hACE1_2468, base LFSR seed; lane k is seeded with LfsrSeed XOR k.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- flush_i  in  1  synchronous pipeline flush.
- in_valid_i  in  1  input beat valid.
- in_ready_o  out  1  input beat accepted when valid && ready.
- abs_value_i  in  NumLanes*AbsWidth  packed absolute values; lane k occupies [k*AbsWidth +: AbsWidth].
- sign_i  in  NumLanes  per-lane sign.
- round_sticky_bits_i  in  2*NumLanes  per-lane {round, sticky}.
- stochastic_bits_i  in  NumLanes*RsrPrecision  per-lane trailing bits used by RSR.
- lane_en_i  in  NumLanes  lane mask; a disabled lane outputs zero and no flags.
- eff_sub_i  in  NumLanes  per-lane effective subtraction.
- rnd_mode_i  in  3  fpnew_pkg::roundmode_e.
- out_valid_o  out  1  output beat valid.
- out_ready_i  in  1  downstream ready.
- abs_rounded_o  out  NumLanes*AbsWidth  rounded magnitudes.
- sign_o  out  NumLanes  result signs.
- exact_zero_o  out  NumLanes  per-lane exact zero.
- inexact_o  out  NumLanes  per-lane round/sticky bits nonzero.
- carry_o  out  NumLanes  per-lane increment overflowed AbsWidth (result wrapped to 0).
- clr_status_i  in  1  clears the accumulated status.
- status_nx_o  out  1  sticky OR of inexact_o over all output handshakes.

Behaviour:
- Reset: every stage valid=0, all data registers 0, status_nx_o=0, lane k LFSR = LfsrSeed^k. out_valid_o=0 and in_ready_o=1 from the cycle after reset is released.
- Rounding decision per lane:
  - RNE: RS=00/01 gives 0; RS=10 gives abs[0]; RS=11 gives 1.
  - RTZ: 0.
  - RDN: |RS ? sign : 0.
  - RUP: |RS ? ~sign : 0.
  - RMM: R.
  - RSR: lfsr[RsrPrecision-1:0] < stochastic_bits.
  - RR: lfsr[RsrPrecision-1].
  - Any other mode code: round_up=0 and inexact_o still reported.
- Rounded value = abs + round_up, computed at AbsWidth+1 bits. The MSB is carry_o; the low AbsWidth bits are abs_rounded_o.
- exact_zero = (abs==0) && (RS==0).
- sign_o = (exact_zero && eff_sub) ? (mode==RDN) : sign.
- LFSR: 32-bit Fibonacci, shift left, feedback = b31^b21^b1^b0.
  - Advances exactly once per accepted input beat, on every enabled lane, in any mode.
  - Holds when no beat is accepted or the lane is disabled.
- Pipeline with NumPipeRegs=N:
  - Latency is N cycles from acceptance to out_valid_o.
  - Stage i ready = ~valid_i | ready_{i+1}; the last stage uses out_ready_i.
  - Full throughput of one beat per cycle while out_ready_i=1.
  - A stalled output holds all out_* stable until the handshake completes.
  - N=0: out_valid_o=in_valid_i, in_ready_o=out_ready_i, outputs combinational.
- Flush:
  - All stage valids clear on the next edge.
  - in_ready_o=0 while flush_i=1; no beat is accepted and no LFSR advances.
  - LFSR state and status are unaffected.
- Status:
  - On each output handshake, status_nx_o |= |inexact_o.
  - clr_status_i clears it. If clear and set occur in the same cycle, set wins.
- Reset asserted mid-operation: in-flight beats are lost and state returns to reset values immediately (asynchronous).

Test Plan:
- RNE ties, NumLanes=4, abs=16'h0003/16'h0002, RS=10 -> 16'h0004/16'h0002; inexact_o=1111; status_nx_o=1 one cycle after the handshake.
- RUP with abs=16'hFFFF, RS=01, sign=0 -> abs_rounded_o=16'h0000, carry_o=1. Same stimulus with sign=1 -> 16'hFFFF, carry_o=0.
- Exact zero: abs=0, RS=00, eff_sub=1. Mode RDN -> sign_o=1; mode RNE -> sign_o=0; exact_zero_o=1 in both.
- Backpressure, N=2: hold out_ready_i=0 for 5 cycles with a stream of 4 beats -> in_ready_o drops after 2 beats are held, no beat lost or duplicated, original order kept on release.
- RSR statistics: stochastic_bits=12'h800 over 4096 beats -> round-up count 2048±128 per lane; lane LFSR sequences differ. Reset then replay -> identical sequence.
- Flush with 2 beats in flight plus a beat presented -> out_valid_o=0 next cycle, presented beat not accepted, LFSR unchanged. clr_status_i and a new inexact beat in the same cycle -> status_nx_o=1.

Source files
------------

// File: rtl/fpnew_rounding_multi.sv
// Multi-lane pipelined FP rounding stage: rounds NumLanes absolute values under
// one rounding mode, with per-lane LFSRs for stochastic/random rounding.

package fpnew_pkg;
  typedef enum logic [2:0] {
    RNE = 3'b000,
    RTZ = 3'b001,
    RDN = 3'b010,
    RUP = 3'b011,
    RMM = 3'b100,
    RSR = 3'b101,
    RR  = 3'b110
  } roundmode_e;
endpackage

module fpnew_rounding_multi
  import fpnew_pkg::*;
#(
  parameter int unsigned NumLanes     = 4,
  parameter int unsigned AbsWidth     = 16,
  parameter int unsigned RsrPrecision = 12,
  parameter int unsigned NumPipeRegs  = 1,
  parameter logic [31:0] LfsrSeed     = 32'hACE1_2468
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               flush_i,
  input  logic                               in_valid_i,
  output logic                               in_ready_o,
  input  logic [NumLanes*AbsWidth-1:0]       abs_value_i,
  input  logic [NumLanes-1:0]                sign_i,
  input  logic [2*NumLanes-1:0]              round_sticky_bits_i,
  input  logic [NumLanes*RsrPrecision-1:0]   stochastic_bits_i,
  input  logic [NumLanes-1:0]                lane_en_i,
  input  logic [NumLanes-1:0]                eff_sub_i,
  input  roundmode_e                         rnd_mode_i,
  output logic                               out_valid_o,
  input  logic                               out_ready_i,
  output logic [NumLanes*AbsWidth-1:0]       abs_rounded_o,
  output logic [NumLanes-1:0]                sign_o,
  output logic [NumLanes-1:0]                exact_zero_o,
  output logic [NumLanes-1:0]                inexact_o,
  output logic [NumLanes-1:0]                carry_o,
  input  logic                               clr_status_i,
  output logic                               status_nx_o
);

  // Per-lane payload: {carry, inexact, exact_zero, sign, rounded}
  localparam int unsigned SumW  = AbsWidth + 1;
  localparam int unsigned LaneW = AbsWidth + 4;
  localparam int unsigned BeatW = NumLanes * LaneW;

  logic [NumLanes-1:0][31:0] lfsr_q, lfsr_d;
  logic [BeatW-1:0]          beat_c;
  logic [BeatW-1:0]          out_beat;
  logic                      accept_c;
  logic                      status_q, status_d;

  function automatic logic [LaneW-1:0] round_lane(
    input logic [AbsWidth-1:0]     abs,
    input logic [1:0]              rs,
    input logic                    sign,
    input logic                    eff_sub,
    input logic [RsrPrecision-1:0] stoch,
    input logic [RsrPrecision-1:0] rnd,
    input roundmode_e              mode
  );
    logic            round_up;
    logic [SumW-1:0] sum;
    logic            zero;
    logic            sgn;
    round_up = 1'b0;
    case (mode)
      RNE: begin
        case (rs)
          2'b10:   round_up = abs[0];
          2'b11:   round_up = 1'b1;
          default: round_up = 1'b0;
        endcase
      end
      RTZ:     round_up = 1'b0;
      RDN:     round_up = (|rs) & sign;
      RUP:     round_up = (|rs) & ~sign;
      RMM:     round_up = rs[1];
      RSR:     round_up = (rnd < stoch);
      RR:      round_up = rnd[RsrPrecision-1];
      default: round_up = 1'b0;
    endcase
    sum  = SumW'(abs) + SumW'(round_up);
    zero = (abs == '0) && (rs == 2'b00);
    sgn  = (zero && eff_sub) ? (mode == RDN) : sign;
    return {sum[AbsWidth], |rs, zero, sgn, sum[AbsWidth-1:0]};
  endfunction

  // Rounding logic for all lanes; disabled lanes produce an all-zero payload
  always_comb begin
    beat_c = '0;
    for (int unsigned k = 0; k < NumLanes; k++) begin
      if (lane_en_i[k]) begin
        beat_c[k*LaneW +: LaneW] = round_lane(
          abs_value_i[k*AbsWidth +: AbsWidth],
          round_sticky_bits_i[2*k +: 2],
          sign_i[k],
          eff_sub_i[k],
          stochastic_bits_i[k*RsrPrecision +: RsrPrecision],
          lfsr_q[k][RsrPrecision-1:0],
          rnd_mode_i);
      end
    end
  end

  assign accept_c = in_valid_i & in_ready_o;

  // LFSR next state: one step per accepted beat on enabled lanes
  always_comb begin
    lfsr_d = lfsr_q;
    for (int unsigned k = 0; k < NumLanes; k++) begin
      if (accept_c && lane_en_i[k]) begin
        lfsr_d[k] = {lfsr_q[k][30:0],
                     lfsr_q[k][31] ^ lfsr_q[k][21] ^ lfsr_q[k][1] ^ lfsr_q[k][0]};
      end
    end
  end

  // LFSR state; each lane gets a distinct seed
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned k = 0; k < NumLanes; k++) begin
        lfsr_q[k] <= LfsrSeed ^ 32'(k);
      end
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  if (NumPipeRegs == 0) begin : g_comb
    assign in_ready_o  = out_ready_i & ~flush_i;
    assign out_valid_o = in_valid_i & ~flush_i;
    assign out_beat    = beat_c;
  end else begin : g_pipe
    logic [NumPipeRegs-1:0]            valid_q;
    logic [NumPipeRegs-1:0][BeatW-1:0] data_q;
    logic [NumPipeRegs:0]              rdy;
    logic [NumPipeRegs:0]              v_chain;
    logic [NumPipeRegs:0][BeatW-1:0]   d_chain;

    // Upstream view of each stage: index 0 is the accepted input beat
    assign v_chain = {valid_q, accept_c};
    assign d_chain = {data_q, beat_c};

    // Stage ready chain, resolved from the output backwards
    always_comb begin
      rdy = '0;
      rdy[NumPipeRegs] = out_ready_i;
      for (int i = int'(NumPipeRegs) - 1; i >= 0; i--) begin
        rdy[i] = ~valid_q[i] | rdy[i+1];
      end
    end

    // Pipeline registers; flush drops every in-flight beat
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        valid_q <= '0;
        data_q  <= '0;
      end else begin
        for (int i = 0; i < int'(NumPipeRegs); i++) begin
          if (flush_i) begin
            valid_q[i] <= 1'b0;
          end else if (rdy[i]) begin
            valid_q[i] <= v_chain[i];
          end
          if (rdy[i] && v_chain[i]) begin
            data_q[i] <= d_chain[i];
          end
        end
      end
    end

    assign in_ready_o  = rdy[0] & ~flush_i;
    assign out_valid_o = valid_q[NumPipeRegs-1];
    assign out_beat    = data_q[NumPipeRegs-1];
  end

  // Unpack the output beat onto the per-lane ports
  always_comb begin
    abs_rounded_o = '0;
    sign_o        = '0;
    exact_zero_o  = '0;
    inexact_o     = '0;
    carry_o       = '0;
    for (int unsigned k = 0; k < NumLanes; k++) begin
      {carry_o[k], inexact_o[k], exact_zero_o[k], sign_o[k],
       abs_rounded_o[k*AbsWidth +: AbsWidth]} = out_beat[k*LaneW +: LaneW];
    end
  end

  // Sticky inexact status; a set in the same cycle as a clear wins
  always_comb begin
    status_d = status_q;
    if (clr_status_i) status_d = 1'b0;
    if (out_valid_o && out_ready_i && (|inexact_o)) status_d = 1'b1;
  end

  // Status register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) status_q <= 1'b0;
    else         status_q <= status_d;
  end

  assign status_nx_o = status_q;

endmodule

// File: tb/tb_fpnew_rounding_multi.sv
// Directed self-checking bench for fpnew_rounding_multi (4 lanes, 2 pipe stages).
module tb_fpnew_rounding_multi;
  import fpnew_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] abs_value = '0;
  logic [3:0]  sign = '0;
  logic [7:0]  rs_bits = '0;
  logic [47:0] stoch = '0;
  logic [3:0]  lane_en = 4'hF;
  logic [3:0]  eff_sub = '0;
  roundmode_e  rnd_mode = RNE;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] abs_rounded;
  logic [3:0]  sign_out, exact_zero, inexact, carry;
  logic        clr_status = 1'b0;
  logic        status_nx;

  int checks = 0;
  int errors = 0;

  int          cnt [4];
  logic [63:0] pat [4];
  logic [63:0] ref_pat [4];

  always #5 clk = ~clk;

  fpnew_rounding_multi #(
    .NumLanes(4), .AbsWidth(16), .RsrPrecision(12),
    .NumPipeRegs(2), .LfsrSeed(32'hACE1_2468)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .abs_value_i(abs_value), .sign_i(sign),
    .round_sticky_bits_i(rs_bits), .stochastic_bits_i(stoch),
    .lane_en_i(lane_en), .eff_sub_i(eff_sub), .rnd_mode_i(rnd_mode),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .abs_rounded_o(abs_rounded), .sign_o(sign_out),
    .exact_zero_o(exact_zero), .inexact_o(inexact), .carry_o(carry),
    .clr_status_i(clr_status), .status_nx_o(status_nx)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_beat(input string tag, input logic [63:0] ea, input logic [3:0] es,
                          input logic [3:0] ez, input logic [3:0] enx, input logic [3:0] ec);
    chk({tag, "_abs"}, abs_rounded, ea);
    chk({tag, "_sign"}, 64'(sign_out), 64'(es));
    chk({tag, "_zero"}, 64'(exact_zero), 64'(ez));
    chk({tag, "_nx"}, 64'(inexact), 64'(enx));
    chk({tag, "_carry"}, 64'(carry), 64'(ec));
  endtask

  function automatic logic [63:0] rep4(input logic [15:0] v);
    return {4{v}};
  endfunction

  task automatic setup(input roundmode_e m, input logic [63:0] a, input logic [3:0] s,
                       input logic [7:0] r, input logic [3:0] e, input logic [3:0] es,
                       input logic [11:0] st);
    rnd_mode = m; abs_value = a; sign = s; rs_bits = r;
    lane_en = e; eff_sub = es; stoch = {4{st}};
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; clr_status = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Present one beat and hold it until accepted (bounded)
  task automatic push();
    int n = 0;
    in_valid = 1'b1;
    #1;
    while (!in_ready && n < 20) begin @(negedge clk); #1; n++; end
    chk("push_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Wait (bounded) for a valid output, leaving time at a negedge
  task automatic wait_out();
    int n = 0;
    @(negedge clk);
    while (!out_valid && n < 20) begin @(negedge clk); n++; end
    chk("out_valid", 64'(out_valid), 64'd1);
  endtask

  // Stream RSR beats at full rate and record per-lane round-up decisions
  task automatic run_rsr(input int nbeats);
    int sent = 0;
    int got  = 0;
    logic acc;
    for (int k = 0; k < 4; k++) begin cnt[k] = 0; pat[k] = '0; end
    for (int cyc = 0; cyc < 6000 && got < nbeats; cyc++) begin
      in_valid = (sent < nbeats);
      #1;
      acc = in_valid && in_ready;
      if (out_valid) begin
        for (int k = 0; k < 4; k++) begin
          cnt[k] += int'(abs_rounded[k*16]);
          if (got < 64) pat[k][got] = abs_rounded[k*16];
        end
        got++;
      end
      @(posedge clk);
      if (acc) sent++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("rsr_beats", 64'(got), 64'(nbeats));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   idx;
    int   nrec;
    logic acc;
    logic [15:0] rec [4];

    // Reset state
    do_reset();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_status", 64'(status_nx), 64'd0);
    chk("rst_abs", abs_rounded, 64'd0);

    // RSR on fresh LFSRs: low 12 bits are 0x468^k, only lane 0 is below 0x469
    setup(RSR, rep4(16'h0010), 4'h0, 8'h00, 4'hF, 4'h0, 12'h469);
    push(); wait_out();
    chk_beat("rsr_first", 64'h0010_0010_0010_0011, 4'h0, 4'h0, 4'h0, 4'h0);

    // RR after one step: bit 11 equals former bit 10, which is 1 on all lanes
    setup(RR, rep4(16'h0020), 4'h0, 8'h00, 4'hF, 4'h0, 12'h000);
    push(); wait_out();
    chk_beat("rr_second", rep4(16'h0021), 4'h0, 4'h0, 4'h0, 4'h0);
    @(negedge clk);
    chk("status_clean", 64'(status_nx), 64'd0);

    // RNE ties with latency of two cycles and status one cycle after handshake
    setup(RNE, 64'h0002_0003_0002_0003, 4'h0, 8'b1010_1010, 4'hF, 4'h0, 12'h000);
    push();
    @(negedge clk);
    chk("rne_latency", 64'(out_valid), 64'd0);
    @(negedge clk);
    chk("rne_valid", 64'(out_valid), 64'd1);
    chk_beat("rne_tie", 64'h0002_0004_0002_0004, 4'h0, 4'h0, 4'hF, 4'h0);
    chk("rne_status_pre", 64'(status_nx), 64'd0);
    @(negedge clk);
    chk("rne_status_post", 64'(status_nx), 64'd1);

    // Clear status alone
    clr_status = 1'b1;
    @(negedge clk);
    clr_status = 1'b0;
    chk("clr_status", 64'(status_nx), 64'd0);

    // RUP overflow on positive lanes, truncation on negative lanes
    setup(RUP, rep4(16'hFFFF), 4'b1100, 8'b0101_0101, 4'hF, 4'h0, 12'h000);
    push(); wait_out();
    chk_beat("rup_wrap", 64'hFFFF_FFFF_0000_0000, 4'b1100, 4'h0, 4'hF, 4'b0011);

    // Exact zero under effective subtraction
    setup(RDN, 64'd0, 4'h0, 8'h00, 4'hF, 4'hF, 12'h000);
    push(); wait_out();
    chk_beat("zero_rdn", 64'd0, 4'hF, 4'hF, 4'h0, 4'h0);
    setup(RNE, 64'd0, 4'h0, 8'h00, 4'hF, 4'hF, 12'h000);
    push(); wait_out();
    chk_beat("zero_rne", 64'd0, 4'h0, 4'hF, 4'h0, 4'h0);

    // RMM with lanes 2,3 disabled
    setup(RMM, rep4(16'h0005), 4'hF, 8'b1010_1010, 4'b0011, 4'h0, 12'h000);
    push(); wait_out();
    chk_beat("rmm_lane_en", 64'h0000_0000_0006_0006, 4'b0011, 4'h0, 4'b0011, 4'h0);

    // RDN with mixed signs
    setup(RDN, rep4(16'h0007), 4'b0101, 8'b0101_0101, 4'hF, 4'h0, 12'h000);
    push(); wait_out();
    chk_beat("rdn_mix", 64'h0007_0008_0007_0008, 4'b0101, 4'h0, 4'hF, 4'h0);

    // RTZ and an undefined mode code never round up
    setup(RTZ, rep4(16'h0007), 4'h0, 8'hFF, 4'hF, 4'h0, 12'h000);
    push(); wait_out();
    chk_beat("rtz", rep4(16'h0007), 4'h0, 4'h0, 4'hF, 4'h0);
    setup(roundmode_e'(3'b111), rep4(16'h0009), 4'h0, 8'hFF, 4'hF, 4'h0, 12'h000);
    push(); wait_out();
    chk_beat("mode7", rep4(16'h0009), 4'h0, 4'h0, 4'hF, 4'h0);

    // Clear and set in the same cycle: set wins
    @(negedge clk);
    clr_status = 1'b1;
    @(negedge clk);
    clr_status = 1'b0;
    chk("status_cleared", 64'(status_nx), 64'd0);
    setup(RNE, 64'h0002_0003_0002_0003, 4'h0, 8'b1010_1010, 4'hF, 4'h0, 12'h000);
    push(); wait_out();
    clr_status = 1'b1;
    @(negedge clk);
    clr_status = 1'b0;
    chk("clr_set_same", 64'(status_nx), 64'd1);

    // Backpressure: output stalled for five cycles while four beats stream in
    @(negedge clk);
    setup(RTZ, 64'd0, 4'h0, 8'h00, 4'hF, 4'h0, 12'h000);
    idx = 0;
    nrec = 0;
    for (int cyc = 0; cyc < 40 && nrec < 4; cyc++) begin
      out_ready = (cyc >= 5);
      if (idx < 4) begin
        abs_value = rep4(16'h0100 + 16'(idx));
        in_valid  = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (cyc == 2) chk("bp_ready_low2", 64'(in_ready), 64'd0);
      if (cyc == 3) begin
        chk("bp_hold_valid", 64'(out_valid), 64'd1);
        chk("bp_hold_data", 64'(abs_rounded[15:0]), 64'h0100);
      end
      if (cyc == 4) chk("bp_ready_low4", 64'(in_ready), 64'd0);
      acc = in_valid && in_ready;
      if (out_valid && out_ready) begin
        rec[nrec] = abs_rounded[15:0];
        nrec++;
      end
      @(posedge clk);
      if (acc) idx++;
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("bp_count", 64'(nrec), 64'd4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("bp_order%0d", i), 64'(rec[i]), 64'(16'h0100 + 16'(i)));
    end

    // Flush with two beats in flight and a third presented
    do_reset();
    out_ready = 1'b0;
    setup(RTZ, rep4(16'h0040), 4'h0, 8'h00, 4'hF, 4'h0, 12'h000);
    push();
    push();
    @(negedge clk);
    abs_value = rep4(16'h0041);
    in_valid  = 1'b1;
    flush     = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("flush_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("flush_valid_clr", 64'(out_valid), 64'd0);
    @(negedge clk);
    @(negedge clk);
    chk("flush_no_stray", 64'(out_valid), 64'd0);
    // Exactly two LFSR steps put low 12 bits in 0x1A0..0x1AF on every lane
    setup(RSR, rep4(16'h0030), 4'h0, 8'h00, 4'hF, 4'h0, 12'h200);
    push(); wait_out();
    chk_beat("flush_lfsr", rep4(16'h0031), 4'h0, 4'h0, 4'h0, 4'h0);

    // RSR statistics at threshold 0x800
    do_reset();
    setup(RSR, 64'd0, 4'h0, 8'h00, 4'hF, 4'h0, 12'h800);
    run_rsr(4096);
    for (int k = 0; k < 4; k++) begin
      ref_pat[k] = pat[k];
      checks++;
      assert (cnt[k] >= 1920 && cnt[k] <= 2176) else begin
        errors++;
        $error("FAIL rsr_count lane%0d: observed %0d expected 2048+-128", k, cnt[k]);
      end
    end
    chk("rsr_diff01", 64'(ref_pat[0] != ref_pat[1]), 64'd1);
    chk("rsr_diff12", 64'(ref_pat[1] != ref_pat[2]), 64'd1);
    chk("rsr_diff23", 64'(ref_pat[2] != ref_pat[3]), 64'd1);

    // Replay after reset reproduces the same decisions
    do_reset();
    run_rsr(64);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rsr_replay%0d", k), pat[k], ref_pat[k]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
